// File: rtl/neg_share_pkg.sv
// Shared types, default sizes and the round-robin pick used by neg_share_ctrl.
package neg_share_pkg;

   localparam int NEG_N_REQ = 4;
   localparam int NEG_WIDTH = 5;
   localparam int RR_MAX    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_t;

   // Walk downward so the nearest valid index after 'last' is written last and wins.
   function automatic int rr_next(input int last, input logic [RR_MAX-1:0] valid, input int n);
      int win;
      int idx;
      win = last;
      for (int k = n; k >= 1; k--) begin
         idx = (last + k) % n;
         if (valid[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/neg_datapath.sv
// Two's-complement negation: bitwise invert, then a half-adder ripple with carry-in 1.
module neg_datapath #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_op,
   output logic [WIDTH-1:0] o_neg,
   output logic             o_carry
);

   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_inv;

   assign w_c[0] = 1'b1;
   assign w_inv  = ~i_op;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ha
      assign o_neg[i]   = w_inv[i] ^ w_c[i];
      assign w_c[i+1]   = w_inv[i] & w_c[i];
   end

   assign o_carry = w_c[WIDTH];

endmodule

// File: rtl/neg_share_ctrl.sv
// Round-robin sharing of one negate datapath among N_REQ requesters.
// Optional NEG_OVF_FLAG_EN adds rsp_ovf, flagging the unrepresentable most-negative operand.
module neg_share_ctrl
   import neg_share_pkg::*;
#(
   parameter int N_REQ = NEG_N_REQ,
   parameter int WIDTH = NEG_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [WIDTH:0]         rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   input  logic                   rsp_ready
`ifdef NEG_OVF_FLAG_EN
   ,
   output logic                   rsp_ovf
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // req_ready is only ever raised in IDLE, and only for the round-robin winner.
   state_t           r_state;
   logic [WIDTH-1:0] r_op;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_last;
   logic             r_rsp_valid;
   logic [WIDTH:0]   r_rsp_data;
   logic [ID_W-1:0]  r_rsp_id;

   logic             w_any;
   logic [ID_W-1:0]  w_winner;
   logic [WIDTH-1:0] w_sel_op;
   logic [WIDTH-1:0] w_neg;
   logic             w_carry;
   logic [N_REQ-1:0] w_one;

   assign w_any    = |req_valid;
   assign w_winner = ID_W'(rr_next(int'(r_last), RR_MAX'(req_valid), N_REQ));
   assign w_sel_op = req_data[w_winner*WIDTH +: WIDTH];
   assign w_one    = {{(N_REQ-1){1'b0}}, 1'b1};

   assign req_ready = ((r_state == IDLE) && w_any) ? (w_one << w_winner) : '0;

   neg_datapath #(.WIDTH(WIDTH)) u_datapath (
      .i_op    (r_op),
      .o_neg   (w_neg),
      .o_carry (w_carry)
   );

`ifdef NEG_OVF_FLAG_EN
   logic r_ovf;
   assign rsp_ovf = r_ovf;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_id        <= '0;
         r_last      <= ID_W'(N_REQ - 1);
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
`ifdef NEG_OVF_FLAG_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op    <= w_sel_op;
                  r_id    <= w_winner;
                  r_state <= COMPUTE;
               end
            end
            COMPUTE: begin
               r_rsp_data  <= {w_carry, w_neg};
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
`ifdef NEG_OVF_FLAG_EN
               r_ovf       <= (r_op == {1'b1, {(WIDTH-1){1'b0}}});
`endif
               r_state     <= RESP;
            end
            RESP: begin
               // Returning to IDLE (not granting here) leaves a gap cycle: no bypass.
               if (rsp_ready) begin
                  r_last      <= r_id;
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_neg_share_ctrl.sv
// Self-checking bench for neg_share_ctrl (N_REQ=4, WIDTH=5); rsp_ovf checks need NEG_OVF_FLAG_EN.
module tb_neg_share_ctrl;
   import neg_share_pkg::*;

   localparam int N = 4;
   localparam int W = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [W:0]     rsp_data;
   logic [1:0]     rsp_id;
   logic           rsp_ready;
`ifdef NEG_OVF_FLAG_EN
   logic           rsp_ovf;
`endif

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         grant_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   neg_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready)
`ifdef NEG_OVF_FLAG_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {carry, 2^W - op mod 2^W}, carry only for a zero operand.
   function automatic logic [W:0] model(input logic [W-1:0] op);
      logic [W:0] diff;
      diff  = 6'd32 - {1'b0, op};
      model = {op == '0, diff[W-1:0]};
   endfunction

   // Driver/monitor: sample handshakes just after the falling edge, then advance one cycle.
   task automatic step();
      #1;
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] && req_valid[i]) begin
            grant_q.push_back(i);
            exp_q.push_back({2'(i), model(req_data[i*W +: W])});
         end
      end
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_data});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d want=%0d", dut.r_state, IDLE); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      n_vec++; if (rsp_data !== 6'b0) begin n_err++; $display("FAIL reset_rsp_data got=%b want=000000", rsp_data); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
   endtask

   task automatic test_single();
      logic [7:0] got, exp;
      rsp_ready = 1'b1;
      req_data  = '0;
      req_data[2*W +: W] = 5'b00011;
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b want=0100", req_ready); end
      step();
      req_valid = '0;
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got=%0b want=0", rsp_valid); end
      step();
      #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%0b want=1", rsp_valid); end
      n_vec++; if (rsp_data !== 6'b011101) begin n_err++; $display("FAIL single_data got=%b want=011101", rsp_data); end
      n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id got=%0d want=2", rsp_id); end
      step();
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_done got=%0b want=0", rsp_valid); end
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL single_sb got=%h want=%h", got, exp); end
      end
   endtask

   task automatic test_zero();
      logic [7:0] got, exp;
      req_data  = '0;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      #1;
      n_vec++; if (rsp_data !== 6'b100000) begin n_err++; $display("FAIL zero_data got=%b want=100000", rsp_data); end
      n_vec++; if (rsp_data[W] !== 1'b1) begin n_err++; $display("FAIL zero_carry got=%0b want=1", rsp_data[W]); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL zero_id got=%0d want=0", rsp_id); end
      step();
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL zero_sb got=%h want=%h", got, exp); end
      end
   endtask

   task automatic test_round_robin();
      int         exp_grant[5] = '{0, 1, 2, 3, 0};
      logic [5:0] exp_data[4]  = '{6'b011111, 6'b011110, 6'b011101, 6'b011100};
      logic [7:0] got, exp;
      int         g;
      do_reset();
      grant_q.delete();
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 5'(i + 1);
      req_valid = 4'b1111;
      repeat (13) step();
      req_valid = '0;
      n_vec++; if (grant_q.size() != 5) begin n_err++; $display("FAIL rr_grant_count got=%0d want=5", grant_q.size()); end
      for (int k = 0; k < 5; k++) begin
         g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
         n_vec++; if (g != exp_grant[k]) begin n_err++; $display("FAIL rr_grant%0d got=%0d want=%0d", k, g, exp_grant[k]); end
      end
      for (int k = 0; k < 4; k++) begin
         got = (k < got_q.size()) ? got_q[k] : 8'hxx;
         n_vec++; if (got[5:0] !== exp_data[k]) begin n_err++; $display("FAIL rr_data%0d got=%b want=%b", k, got[5:0], exp_data[k]); end
      end
      repeat (2) step();
      n_vec++; if (got_q.size() != 5) begin n_err++; $display("FAIL rr_rsp_count got=%0d want=5", got_q.size()); end
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL rr_sb got=%h want=%h", got, exp); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] got, exp;
      rsp_ready = 1'b0;
      req_data  = '0;
      req_data[1*W +: W] = 5'd5;
      req_data[3*W +: W] = 5'd9;
      req_valid = 4'b0010;
      step();
      req_valid = 4'b1000;
      step();
      for (int c = 0; c < 5; c++) begin
         #1;
         n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d got=%0b want=1", c, rsp_valid); end
         n_vec++; if (rsp_data !== 6'b011011) begin n_err++; $display("FAIL bp_data%0d got=%b want=011011", c, rsp_data); end
         n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_id%0d got=%0d want=1", c, rsp_id); end
         n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_ready%0d got=%b want=0000", c, req_ready); end
         step();
      end
      rsp_ready = 1'b1;
      step();
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next_grant got=%b want=1000", req_ready); end
      step();
      req_valid = '0;
      repeat (2) step();
      n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL bp_rsp_count got=%0d want=2", got_q.size()); end
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL bp_sb got=%h want=%h", got, exp); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got, exp;
      rsp_ready = 1'b1;
      req_data  = '0;
      req_data[1*W +: W] = 5'd7;
      req_data[2*W +: W] = 5'd6;
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      repeat (2) step();
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL mid_pre_sb got=%h want=%h", got, exp); end
      end
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      #1;
      n_vec++; if (dut.r_state !== COMPUTE) begin n_err++; $display("FAIL mid_in_compute got=%0d want=%0d", dut.r_state, COMPUTE); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      #1;
      n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL mid_state got=%0d want=%0d", dut.r_state, IDLE); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got=%0b want=0", rsp_valid); end
      req_valid = 4'b1111;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_priority got=%b want=0001", req_ready); end
      req_valid = '0;
      repeat (4) step();
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL mid_aborted_rsp got=%0d want=0", got_q.size()); end
   endtask

   task automatic test_boundary();
      logic [4:0] ops[2]  = '{5'b10000, 5'b01111};
      logic [5:0] exps[2] = '{6'b010000, 6'b010001};
      logic       ovfs[2] = '{1'b1, 1'b0};
      logic [7:0] got, exp;
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_data = '0;
         req_data[2*W +: W] = ops[k];
         req_valid = 4'b0100;
         step();
         req_valid = '0;
         step();
         #1;
         n_vec++; if (rsp_data !== exps[k]) begin n_err++; $display("FAIL edge_data%0d got=%b want=%b", k, rsp_data, exps[k]); end
`ifdef NEG_OVF_FLAG_EN
         n_vec++; if (rsp_ovf !== ovfs[k]) begin n_err++; $display("FAIL edge_ovf%0d got=%0b want=%0b", k, rsp_ovf, ovfs[k]); end
`else
         if (ovfs[k] === 1'bx) $display("note: ovf table entry %0d unknown", k);
`endif
         step();
      end
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL edge_sb got=%h want=%h", got, exp); end
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_zero();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_boundary();
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
